axis_adder_tx: RTL and testbench
================================

# axis_adder_tx

Transmit-side companion to the stream FIFO/adder top level. Accepts operand pairs over a valid/ready handshake, computes the sum in the c_WIDTH adder domain, and emits each result as one AXI4-Stream beat. Beats are grouped into frames of FRAME_LEN beats, or fewer when the producer ends a frame early. A 2-entry skid buffer sustains full throughput under backpressure, and the block drives the slave side of the downstream AXI-Stream FIFO.

## Interface
- DATA_WIDTH, 8, output tdata width; must be >= c_WIDTH+1
- KEEP_WIDTH, (DATA_WIDTH+7)/8, tkeep width
- USER_WIDTH, 1, tuser width
- c_WIDTH, 4, operand width
- FRAME_LEN, 4, beats per full frame; must be >= 1
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- value_a  in  c_WIDTH  operand A, unsigned
- value_b  in  c_WIDTH  operand B, unsigned
- in_valid  in  1  operand pair valid
- in_last  in  1  force end-of-frame on this pair
- in_ready  out  1  block can accept a pair
- m_axis_tdata  out  DATA_WIDTH  zero-extended sum
- m_axis_tkeep  out  KEEP_WIDTH  all ones while tvalid, else 0
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last beat of frame
- m_axis_tuser  out  USER_WIDTH  bit0 = frame carry flag on the tlast beat, else 0; upper bits 0
- status_frame_sent  out  1  one-cycle pulse on each tlast handshake
- frame_count  out  16  count of tlast handshakes

## Operation
- Accept: a pair is accepted when in_valid && in_ready. Sum = value_a + value_b, computed at c_WIDTH+1 bits and zero-extended to DATA_WIDTH.
- Beat counter beat_cnt runs 0..FRAME_LEN-1 and advances on each accept.
  - tlast is set on the accepted beat when beat_cnt == FRAME_LEN-1 or in_last = 1; beat_cnt then returns to 0.
  - in_last on a beat that already closes a full frame has no extra effect.
- Carry flag: carry_acc ORs sum[c_WIDTH] over the accepted beats of the current frame, including the closing beat.
  - tuser[0] on the tlast beat = carry_acc | sum[c_WIDTH] of that beat.
  - carry_acc clears when the frame closes.
- Skid buffer states: EMPTY (no beat held), ONE (output register holds a beat), TWO (output and skid registers both hold beats).
  - EMPTY --accept--> ONE.
  - ONE --accept without output handshake--> TWO.
  - ONE --output handshake without accept--> EMPTY.
  - ONE --accept and output handshake--> ONE, output register reloads with the new beat.
  - TWO --output handshake--> ONE, skid register moves into the output register.
- in_ready is registered. It is 1 in EMPTY and ONE, and 0 in TWO. No accept is possible in TWO.
- Output fields (tdata, tlast, tuser) hold stable while tvalid = 1 and tready = 0.
- frame_count increments on each tlast handshake and wraps 0xFFFF -> 0. status_frame_sent pulses in the cycle after that handshake.
- Reset (rst = 0, asynchronous): state EMPTY, beat_cnt = 0, carry_acc = 0, frame_count = 0.
  - All outputs are 0, including in_ready.
  - A reset mid-frame discards held beats. No tlast is emitted for the partial frame, and the next frame starts at beat 0.

## Timing
- Accept-to-tvalid latency is 1 cycle: a pair accepted at edge N appears on m_axis_* after edge N.
- in_ready rises at the first rising edge after rst deasserts.
- Throughput is 1 beat/cycle while m_axis_tready = 1.
- After in_ready drops, at most 2 beats are held; in_ready returns to 1 one cycle after the output handshake that leaves TWO.
- No combinational path from m_axis_tready to in_ready. in_ready and all m_axis_* outputs are register outputs.
- Simultaneous accept and output handshake in ONE gives no bubble.
- Simultaneous output handshake in TWO and in_valid: the pair is not accepted that cycle.

## Test plan
- Reset: rst low mid-run. All outputs read 0 immediately. After release, in_ready = 1 at the first edge and frame_count = 0.
- Full frame, tready = 1: pairs (3,4), (15,1), (7,7), (15,15).
  - tdata = 7, 16, 14, 30; tlast only on the 4th beat; tuser = 1 on the 4th beat only.
  - status_frame_sent pulses once; frame_count = 1.
- Backpressure: stream 6 pairs with tready held 0 for 4 cycles after the first beat.
  - in_ready drops after 2 beats are held.
  - No beat is lost or duplicated; order is preserved; tdata is stable while stalled.
- Early end: pairs (1,1) then (2,2) with in_last = 1.
  - tdata = 2, 4; tlast on the 2nd beat; tuser = 0.
  - The next frame of 4 pairs has tlast on its 4th beat.
- Reset mid-frame: 2 beats into a frame, pulse rst.
  - No tlast is seen; tvalid = 0 during reset.
  - The following 4 pairs form a complete frame with tlast on beat 4.
- Counter wrap: preload frame_count to 0xFFFF via 65535 single-beat frames (in_last = 1). One more frame gives frame_count = 0.

Source files
------------

// File: rtl/axis_adder_tx_if.sv
// Operand-pair input and AXI4-Stream output bundle for axis_adder_tx.
// slave: the adder's view; master: the producer/sink environment view.
interface axis_adder_tx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int USER_WIDTH = 1,
  parameter int c_WIDTH    = 4
);
  logic [c_WIDTH-1:0]    value_a;
  logic [c_WIDTH-1:0]    value_b;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic [KEEP_WIDTH-1:0] m_axis_tkeep;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;
  logic [USER_WIDTH-1:0] m_axis_tuser;

  modport slave (
    input  value_a,
    input  value_b,
    input  in_valid,
    input  in_last,
    output in_ready,
    output m_axis_tdata,
    output m_axis_tkeep,
    output m_axis_tvalid,
    input  m_axis_tready,
    output m_axis_tlast,
    output m_axis_tuser
  );

  modport master (
    output value_a,
    output value_b,
    output in_valid,
    output in_last,
    input  in_ready,
    input  m_axis_tdata,
    input  m_axis_tkeep,
    input  m_axis_tvalid,
    output m_axis_tready,
    input  m_axis_tlast,
    input  m_axis_tuser
  );
endinterface

// File: rtl/axis_adder_tx.sv
// Adds operand pairs and emits framed AXI4-Stream beats via a 2-entry skid.
// Ports: clk, rst (async active-low), io (pairs in / m_axis out), status.
module axis_adder_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int USER_WIDTH = 1,
  parameter int c_WIDTH    = 4,
  parameter int FRAME_LEN  = 4
) (
  input  logic                clk,
  input  logic                rst,
  axis_adder_tx_if.slave      io,
  output logic                status_frame_sent,
  output logic [15:0]         frame_count
);

  localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_TWO
  } state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic [USER_WIDTH-1:0] user;
  } beat_t;

  state_e          state_q, state_d;
  beat_t           out_q, out_d;
  beat_t           skid_q, skid_d;
  logic [BW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic            rdy_q, rdy_d;
  logic            vld_q, vld_d;
  logic            sent_q, sent_d;
  logic [15:0]     fcnt_q, fcnt_d;

  logic [c_WIDTH:0] sum;
  logic             closes;
  logic             accept;
  logic             out_hs;
  beat_t            new_beat;

  assign accept = io.in_valid & rdy_q;
  assign out_hs = vld_q & io.m_axis_tready;

  always_comb begin
    sum      = {1'b0, io.value_a} + {1'b0, io.value_b};
    closes   = (cnt_q == LAST_IDX) | io.in_last;
    new_beat = '0;
    new_beat.data = DATA_WIDTH'(sum);
    new_beat.last = closes;
    // Frame carry is reported only on the closing beat.
    new_beat.user[0] = closes & (carry_q | sum[c_WIDTH]);
  end

  always_comb begin
    cnt_d   = cnt_q;
    carry_d = carry_q;
    if (accept) begin
      if (closes) begin
        cnt_d   = '0;
        carry_d = 1'b0;
      end else begin
        cnt_d   = cnt_q + BW'(1);
        carry_d = carry_q | sum[c_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d = S_ONE;
          out_d   = new_beat;
        end
      end
      S_ONE: begin
        unique case (1'b1)
          (accept & ~out_hs): begin
            state_d = S_TWO;
            skid_d  = new_beat;
          end
          (~accept & out_hs): begin
            state_d = S_EMPTY;
            out_d   = '0;
          end
          (accept & out_hs): begin
            out_d = new_beat;
          end
          default: ;
        endcase
      end
      S_TWO: begin
        if (out_hs) begin
          state_d = S_ONE;
          out_d   = skid_q;
          skid_d  = '0;
        end
      end
      default: begin
        state_d = S_EMPTY;
        out_d   = '0;
        skid_d  = '0;
      end
    endcase
  end

  // Ready and valid are derived from the next state so both are flops.
  always_comb begin
    rdy_d  = (state_d != S_TWO);
    vld_d  = (state_d != S_EMPTY);
    sent_d = out_hs & out_q.last;
    fcnt_d = fcnt_q + 16'(out_hs & out_q.last);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      sent_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      sent_q  <= sent_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign io.in_ready      = rdy_q;
  assign io.m_axis_tdata  = out_q.data;
  assign io.m_axis_tkeep  = {KEEP_WIDTH{vld_q}};
  assign io.m_axis_tvalid = vld_q;
  assign io.m_axis_tlast  = out_q.last;
  assign io.m_axis_tuser  = out_q.user;
  assign status_frame_sent = sent_q;
  assign frame_count       = fcnt_q;

endmodule

// File: tb/tb_axis_adder_tx.sv
// Self-checking bench for axis_adder_tx: directed and random streams
// compared against a frame-level reference model.
module tb_axis_adder_tx;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int FL = 4;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sent;
  logic [15:0] fcount;

  axis_adder_tx_if #(.DATA_WIDTH(DW), .USER_WIDTH(1), .c_WIDTH(CW)) io ();

  axis_adder_tx #(
    .DATA_WIDTH(DW), .USER_WIDTH(1), .c_WIDTH(CW), .FRAME_LEN(FL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io(io.slave),
    .status_frame_sent(sent),
    .frame_count(fcount)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  beat_t       q[$];
  beat_t       seen[$];
  int          cur[$];
  int          src_a[$];
  int          src_b[$];
  bit          src_l[$];
  logic [15:0] exp_frames = 0;
  bit          stall_prev = 0;
  beat_t       held;
  bit          saw_stall = 0;
  int          sent_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: sums grouped into frames; a frame closes on its FL-th
  // pair or on in_last, and flags carry if any of its sums overflowed.
  function automatic void model_accept(int a, int b, bit lst);
    int  s;
    bit  close;
    bit  u;
    s = a + b;
    cur.push_back(s);
    close = lst || (cur.size() == FL);
    u = 0;
    if (close) begin
      foreach (cur[i]) if (cur[i] >= 16) u = 1;
      cur.delete();
    end
    q.push_back('{d: 8'(s), l: close, u: u});
  endfunction

  task automatic tick(output bit acc);
    bit    hs;
    bit    closed;
    beat_t e;
    beat_t o;
    acc = io.in_valid && io.in_ready;
    hs  = io.m_axis_tvalid && io.m_axis_tready;
    o = '{d: io.m_axis_tdata, l: io.m_axis_tlast, u: io.m_axis_tuser[0]};
    chk("tvalid", 32'(io.m_axis_tvalid), 32'(q.size() > 0));
    chk("in_ready", 32'(io.in_ready), 32'(q.size() < 2));
    chk("tkeep", 32'(io.m_axis_tkeep), 32'(io.m_axis_tvalid));
    if (!io.in_ready) saw_stall = 1;
    if (stall_prev) begin
      chk("stable_data", 32'(o.d), 32'(held.d));
      chk("stable_last", 32'(o.l), 32'(held.l));
      chk("stable_user", 32'(o.u), 32'(held.u));
    end
    closed = 0;
    if (hs) begin
      if (q.size() == 0) begin
        chk("spurious_beat", 32'(q.size()), 32'd1);
      end else begin
        e = q.pop_front();
        chk("tdata", 32'(o.d), 32'(e.d));
        chk("tlast", 32'(o.l), 32'(e.l));
        chk("tuser", 32'(o.u), 32'(e.u));
        seen.push_back(o);
        closed = e.l;
      end
    end
    if (acc) model_accept(int'(io.value_a), int'(io.value_b), io.in_last);
    stall_prev = io.m_axis_tvalid && !io.m_axis_tready;
    held = o;
    if (closed) exp_frames++;
    @(posedge clk);
    @(negedge clk);
    if (sent) sent_cnt++;
    chk("frame_sent", 32'(sent), 32'(closed));
    chk("frame_count", 32'(fcount), 32'(exp_frames));
  endtask

  // Feeds queued pairs, with tready low in a window or randomly,
  // then drains every held beat.
  task automatic run(input int sf, input int sl, input bit rnd);
    int cyc;
    bit acc;
    cyc = 0;
    while ((src_a.size() > 0 || q.size() > 0) && cyc < 1000) begin
      io.in_valid = (src_a.size() > 0);
      io.value_a  = (src_a.size() > 0) ? 4'(src_a[0]) : 4'd0;
      io.value_b  = (src_a.size() > 0) ? 4'(src_b[0]) : 4'd0;
      io.in_last  = (src_a.size() > 0) ? src_l[0] : 1'b0;
      if (rnd) io.m_axis_tready = 1'($urandom_range(0, 1));
      else     io.m_axis_tready = !(cyc >= sf && cyc < sf + sl);
      tick(acc);
      if (acc) begin
        void'(src_a.pop_front());
        void'(src_b.pop_front());
        void'(src_l.pop_front());
      end
      cyc++;
    end
    chk("drain_bound", 32'(cyc < 1000), 32'd1);
    io.in_valid = 1'b0;
    io.in_last  = 1'b0;
    io.m_axis_tready = 1'b1;
  endtask

  task automatic push(input int a, input int b, input bit l);
    src_a.push_back(a);
    src_b.push_back(b);
    src_l.push_back(l);
  endtask

  task automatic do_reset();
    io.in_valid = 1'b0;
    io.in_last  = 1'b0;
    io.value_a  = '0;
    io.value_b  = '0;
    io.m_axis_tready = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_tvalid", 32'(io.m_axis_tvalid), 32'd0);
    chk("rst_tdata", 32'(io.m_axis_tdata), 32'd0);
    chk("rst_tlast", 32'(io.m_axis_tlast), 32'd0);
    chk("rst_tuser", 32'(io.m_axis_tuser), 32'd0);
    chk("rst_tkeep", 32'(io.m_axis_tkeep), 32'd0);
    chk("rst_in_ready", 32'(io.in_ready), 32'd0);
    chk("rst_sent", 32'(sent), 32'd0);
    chk("rst_fcount", 32'(fcount), 32'd0);
    q.delete();
    cur.delete();
    stall_prev = 0;
    exp_frames = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold_tvalid", 32'(io.m_axis_tvalid), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_in_ready", 32'(io.in_ready), 32'd1);
    chk("post_rst_fcount", 32'(fcount), 32'd0);
    io.m_axis_tready = 1'b1;
  endtask

  initial begin
    bit acc;
    int s0;
    io.in_valid = 1'b0;
    io.in_last  = 1'b0;
    io.value_a  = '0;
    io.value_b  = '0;
    io.m_axis_tready = 1'b1;
    @(negedge clk);
    do_reset();

    // Full frame at full throughput.
    seen.delete();
    s0 = sent_cnt;
    push(3, 4, 0);
    push(15, 1, 0);
    push(7, 7, 0);
    push(15, 15, 0);
    run(0, 0, 0);
    chk("ff_count", 32'(seen.size()), 32'd4);
    if (seen.size() == 4) begin
      chk("ff_d0", 32'(seen[0].d), 32'd7);
      chk("ff_d1", 32'(seen[1].d), 32'd16);
      chk("ff_d2", 32'(seen[2].d), 32'd14);
      chk("ff_d3", 32'(seen[3].d), 32'd30);
      chk("ff_lasts", 32'({seen[0].l, seen[1].l, seen[2].l, seen[3].l}),
          32'b0001);
      chk("ff_users", 32'({seen[0].u, seen[1].u, seen[2].u, seen[3].u}),
          32'b0001);
    end
    chk("ff_pulses", 32'(sent_cnt - s0), 32'd1);
    chk("ff_fcount", 32'(fcount), 32'd1);

    // Backpressure: tready low for 4 cycles after the first beat.
    seen.delete();
    saw_stall = 0;
    for (int i = 0; i < 6; i++)
      push($urandom_range(0, 15), $urandom_range(0, 15), i == 5);
    run(1, 4, 0);
    chk("bp_count", 32'(seen.size()), 32'd6);
    chk("bp_ready_dropped", 32'(saw_stall), 32'd1);

    // Early frame end, then a full frame.
    seen.delete();
    push(1, 1, 0);
    push(2, 2, 1);
    for (int i = 0; i < 4; i++)
      push($urandom_range(0, 15), $urandom_range(0, 15), 0);
    run(0, 0, 0);
    chk("ee_count", 32'(seen.size()), 32'd6);
    if (seen.size() == 6) begin
      chk("ee_d0", 32'(seen[0].d), 32'd2);
      chk("ee_d1", 32'(seen[1].d), 32'd4);
      chk("ee_l0", 32'(seen[0].l), 32'd0);
      chk("ee_l1", 32'(seen[1].l), 32'd1);
      chk("ee_u1", 32'(seen[1].u), 32'd0);
      chk("ee_l4", 32'(seen[4].l), 32'd0);
      chk("ee_l5", 32'(seen[5].l), 32'd1);
    end

    // Reset with two beats held mid-frame.
    seen.delete();
    io.m_axis_tready = 1'b0;
    io.in_valid = 1'b1;
    io.in_last  = 1'b0;
    io.value_a  = 4'd9;
    io.value_b  = 4'd9;
    tick(acc);
    io.value_a  = 4'd2;
    io.value_b  = 4'd3;
    tick(acc);
    chk("mid_held", 32'(q.size()), 32'd2);
    do_reset();
    for (int i = 0; i < 4; i++) push(i, i + 1, 0);
    run(0, 0, 0);
    chk("mr_count", 32'(seen.size()), 32'd4);
    if (seen.size() == 4) begin
      chk("mr_lasts", 32'({seen[0].l, seen[1].l, seen[2].l, seen[3].l}),
          32'b0001);
      chk("mr_d0", 32'(seen[0].d), 32'd1);
    end
    chk("mr_fcount", 32'(fcount), 32'd1);

    // Random operands, random in_last, random backpressure.
    for (int i = 0; i < 60; i++)
      push($urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 7) == 0);
    run(0, 0, 1);

    // Frame counter wrap via single-beat frames.
    do_reset();
    io.in_valid = 1'b1;
    io.in_last  = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      io.value_a = 4'($urandom_range(0, 15));
      io.value_b = 4'($urandom_range(0, 15));
      tick(acc);
    end
    io.in_valid = 1'b0;
    io.in_last  = 1'b0;
    tick(acc);
    chk("wrap_ffff", 32'(fcount), 32'h0000FFFF);
    push(5, 9, 1);
    run(0, 0, 0);
    chk("wrap_zero", 32'(fcount), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
